seq_restoring_divider: RTL and testbench
========================================

Name: seq_restoring_divider

Overview:
- Iterative restoring divider: 2*WIDTH-bit dividend by WIDTH-bit divisor, giving a WIDTH-bit quotient and a WIDTH-bit remainder.
- Inverse of the team's combinational 16x16 multiplier: dividing its product by either operand returns the other operand with remainder 0.
- Multi-cycle block with a start/busy/done handshake, one quotient bit per clock.
- Used wherever the datapath must undo a scaling product or normalise an accumulated sum.

Parameters:
- WIDTH, 16, divisor/quotient/remainder width; dividend width is 2*WIDTH; must be at least 2. Must be even when DIV_TWO_BITS_PER_CYCLE_EN is defined.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- start  input  1  request; sampled only when busy=0
- dividend  input  2*WIDTH  numerator; latched on accepted start
- divisor  input  WIDTH  denominator; latched on accepted start
- busy  output  1  high in RUN and FINISH
- done  output  1  one-cycle pulse; results valid in that cycle
- quotient  output  WIDTH  result; held until the next accepted start
- remainder  output  WIDTH  result; held until the next accepted start
- div_by_zero  output  1  error flag for the last operation; held like the results
- overflow  output  1  error flag for the last operation (quotient does not fit); held like the results

Behaviour:
- Reset (asynchronous, any state):
  - state=IDLE; busy, done, quotient, remainder, div_by_zero and overflow all 0; iteration counter 0.
  - Reset mid-RUN aborts the operation; no done is issued.
- States: IDLE, RUN, FINISH. busy=(state!=IDLE); done=(state==FINISH).
- IDLE, start=1 at edge E0:
  - Latch the operands and clear both flags.
  - divisor==0: set div_by_zero, quotient=all ones, remainder=0, go to FINISH.
  - Else if dividend[2W-1:W] >= divisor: set overflow, quotient=all ones, remainder=0, go to FINISH.
  - Else: partial remainder P (W+1 bits) = {0, dividend[2W-1:W]}, shift register S = dividend[W-1:0], counter=0, go to RUN.
- RUN, each edge:
  - T = {P[W-1:0], S[W-1]}.
  - If T >= divisor: P=T-divisor, qbit=1; else P=T, qbit=0.
  - S = {S[W-2:0], qbit}; counter+1.
  - The edge with counter==W-1 writes quotient=final S and remainder=P[W-1:0], then goes to FINISH.
- FINISH: lasts one cycle, then IDLE.
- Latency:
  - Normal operation: done is high in the cycle after edge E0+W, i.e. W cycles after the start edge.
  - Error cases: done is high in the cycle after E0.
  - Minimum start-to-start spacing is W+2 cycles.
- start while busy=1 is ignored, with no queuing, including during FINISH.
- Operand inputs are don't-care except at the accepting edge.
- Invariant when neither flag is set: dividend == quotient*divisor + remainder, and remainder < divisor.
- Output registers change only at the accepting edge (flags clear, error results load) and at the final RUN edge.

Optional Feature:
- Macro DIV_TWO_BITS_PER_CYCLE_EN.
- Defined:
  - RUN performs two restoring iterations per edge, chained combinationally.
  - RUN lasts W/2 edges; done is high in the cycle after edge E0+W/2.
  - Results and error handling are identical.
- Undefined: one bit per edge as specified above.

Test Plan:
- 0x0001E240 / 0x03E8 -> quotient 0x007B, remainder 0x01C8, flags 0; done is a single-cycle pulse 16 cycles after the start edge (8 with the macro).
- Multiplier round-trip 0xFFFE0001 / 0xFFFF -> quotient 0xFFFF, remainder 0x0000. Also sweep random a,b, dividing a*b by b, and expect quotient a and remainder 0.
- Divisor 0 with dividend 0x12345678 -> div_by_zero=1, quotient 0xFFFF, remainder 0, done 1 cycle after start. The next valid start clears the flag.
- 0x00100000 / 0x0010 -> overflow=1, quotient 0xFFFF, remainder 0, done after 1 cycle. 0x000FFFFF / 0x0010 -> quotient 0xFFFF, remainder 0x000F, no flags.
- Pulse start at cycles 3, 8 and 17 of a run -> all ignored; the results are those of the first operation only.
- Assert rst during RUN at iteration 7 -> all outputs 0, no done. A start after rst deassertion completes with correct results.

Source files
------------

// File: rtl/seq_restoring_divider.sv
// seq_restoring_divider: iterative restoring divider, 2*WIDTH-bit dividend by WIDTH-bit divisor.
// Define DIV_TWO_BITS_PER_CYCLE_EN to retire two quotient bits per clock (WIDTH must then be even).
module seq_restoring_divider #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [2*WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0]   divisor,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   quotient,
    output logic [WIDTH-1:0]   remainder,
    output logic               div_by_zero,
    output logic               overflow
);
    localparam int CW = $clog2(WIDTH);
`ifdef DIV_TWO_BITS_PER_CYCLE_EN
    localparam logic [CW-1:0] LAST = CW'(WIDTH / 2 - 1);
`else
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
`endif
    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;
    state_t state, state_nx;
    logic [WIDTH-1:0] p, p_nx, s, s_nx, dvs;
    logic [CW-1:0] cnt;
    logic div_zero, ovf;
    // Partial remainder stays below the divisor, so only its low WIDTH bits are stored;
    // the shifted-out top bit forces a subtract on its own.
    function automatic logic [2*WIDTH-1:0] step(input logic [WIDTH-1:0] pp, input logic [WIDTH-1:0] ss,
                                                input logic [WIDTH-1:0] d);
        logic [WIDTH:0] t;
        logic q;
        t = {pp, ss[WIDTH-1]};
        q = t[WIDTH] || (t[WIDTH-1:0] >= d);
        return {q ? t[WIDTH-1:0] - d : t[WIDTH-1:0], ss[WIDTH-2:0], q};
    endfunction
`ifdef DIV_TWO_BITS_PER_CYCLE_EN
    logic [2*WIDTH-1:0] mid;
    always_comb begin
        mid = step(p, s, dvs);
        {p_nx, s_nx} = step(mid[2*WIDTH-1:WIDTH], mid[WIDTH-1:0], dvs);
    end
`else
    always_comb {p_nx, s_nx} = step(p, s, dvs);
`endif
    assign div_zero = divisor == '0;
    assign ovf = dividend[2*WIDTH-1:WIDTH] >= divisor;
    assign busy = state != IDLE;
    assign done = state == FINISH;
    always_comb begin
        state_nx = state;
        if (state == IDLE)
            state_nx = start ? ((div_zero || ovf) ? FINISH : RUN) : IDLE;
        else if (state == RUN)
            state_nx = (cnt == LAST) ? FINISH : RUN;
        else
            state_nx = IDLE;
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else state <= state_nx;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p           <= '0;
            s           <= '0;
            dvs         <= '0;
            cnt         <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else if (state == IDLE && start) begin
            dvs         <= divisor;
            p           <= dividend[2*WIDTH-1:WIDTH];
            s           <= dividend[WIDTH-1:0];
            cnt         <= '0;
            div_by_zero <= div_zero;
            overflow    <= !div_zero && ovf;
            if (div_zero || ovf) begin
                quotient  <= '1;
                remainder <= '0;
            end
        end else if (state == RUN) begin
            p   <= p_nx;
            s   <= s_nx;
            cnt <= cnt + 1'b1;
            if (cnt == LAST) begin
                quotient  <= s_nx;
                remainder <= p_nx;
            end
        end
    end
endmodule

// File: tb/tb_seq_restoring_divider.sv
// tb_seq_restoring_divider: vector table plus scoreboard for seq_restoring_divider,
// with hand-written sequences for ignored starts and mid-run reset.
module tb_seq_restoring_divider;
    localparam int W = 16;
`ifdef DIV_TWO_BITS_PER_CYCLE_EN
    localparam int L = W / 2;
`else
    localparam int L = W;
`endif
    logic clk = 0, rst = 1, start = 0;
    logic [2*W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic busy, done, div_by_zero, overflow;
    logic [W-1:0] quotient, remainder;
    int cyc = 0, checks = 0, failures = 0;

    typedef struct {logic [W-1:0] q, r; logic dz, ov; int cyc;} exp_t;
    typedef struct {logic [2*W-1:0] a; logic [W-1:0] b, q, r; logic dz, ov;} vec_t;
    exp_t sb[$];
    vec_t vt[10];

    seq_restoring_divider #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
        .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
        .div_by_zero(div_by_zero), .overflow(overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", n, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && done) begin
            if (sb.size() == 0) chk("spurious_done", 32'(done), 32'(0));
            else begin
                exp_t e;
                e = sb.pop_front();
                chk("quotient", 32'(quotient), 32'(e.q));
                chk("remainder", 32'(remainder), 32'(e.r));
                chk("flags", {30'b0, div_by_zero, overflow}, {30'b0, e.dz, e.ov});
                chk("done_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (busy) chk("idle_timeout", 32'(busy), 32'(0));
    endtask

    task automatic run_op(input logic [2*W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] q, r,
                          input logic dz, ov);
        exp_t e;
        wait_idle();
        @(negedge clk);
        dividend = a;
        divisor = b;
        start = 1;
        @(posedge clk);
        #1;
        start = 0;
        dividend = $urandom;
        divisor = 16'($urandom);
        e.q = q; e.r = r; e.dz = dz; e.ov = ov;
        e.cyc = cyc + ((dz || ov) ? 0 : L);
        sb.push_back(e);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() > 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 32'(sb.size()), 32'(0));
    endtask

    initial begin
        int k;
        vt[0] = '{32'h0001E240, 16'h03E8, 16'h007B, 16'h01C8, 1'b0, 1'b0};
        vt[1] = '{32'hFFFE0001, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b0, 1'b0};
        vt[2] = '{32'h12345678, 16'h0000, 16'hFFFF, 16'h0000, 1'b1, 1'b0};
        vt[3] = '{32'h00000064, 16'h0007, 16'h000E, 16'h0002, 1'b0, 1'b0};
        vt[4] = '{32'h00100000, 16'h0010, 16'hFFFF, 16'h0000, 1'b0, 1'b1};
        vt[5] = '{32'h000FFFFF, 16'h0010, 16'hFFFF, 16'h000F, 1'b0, 1'b0};
        vt[6] = '{32'h00000000, 16'h0001, 16'h0000, 16'h0000, 1'b0, 1'b0};
        vt[7] = '{32'h0000FFFF, 16'hFFFF, 16'h0001, 16'h0000, 1'b0, 1'b0};
        vt[8] = '{32'h7FFF8000, 16'h8000, 16'hFFFF, 16'h0000, 1'b0, 1'b0};
        vt[9] = '{32'hFFFFFFFF, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b0, 1'b1};
        repeat (2) @(negedge clk);
        chk("reset_ctrl", {28'b0, busy, done, div_by_zero, overflow}, 32'(0));
        chk("reset_q", 32'(quotient), 32'(0));
        chk("reset_r", 32'(remainder), 32'(0));
        rst = 0;
        for (int i = 0; i < 10; i++) run_op(vt[i].a, vt[i].b, vt[i].q, vt[i].r, vt[i].dz, vt[i].ov);
        for (int i = 0; i < 8; i++) begin
            logic [W-1:0] a, b;
            a = 16'($urandom);
            b = 16'($urandom_range(1, 65535));
            run_op(a * b, b, a, '0, 1'b0, 1'b0);
        end
        drain();
        // starts during RUN and FINISH must be dropped
        run_op(32'h0001E240, 16'h03E8, 16'h007B, 16'h01C8, 1'b0, 1'b0);
        k = cyc;
        for (int i = 0; i <= L; i++) begin
            @(negedge clk);
            start = (i == 2 || i == L / 2 || i == L);
            dividend = 32'h00000064;
            divisor = 16'h0007;
            if (cyc != k + i) chk("ignore_align", 32'(cyc), 32'(k + i));
        end
        @(negedge clk);
        start = 0;
        drain();
        repeat (3) @(negedge clk);
        chk("ignore_busy", 32'(busy), 32'(0));
        chk("ignore_q", 32'(quotient), 32'h007B);
        chk("ignore_r", 32'(remainder), 32'h01C8);
        // reset in the middle of an operation
        run_op(32'h00000064, 16'h0007, 16'h000E, 16'h0002, 1'b0, 1'b0);
        repeat (8) @(negedge clk);
        chk("pre_rst_busy", 32'(busy), 32'(1));
        rst = 1;
        #1;
        chk("rst_ctrl", {28'b0, busy, done, div_by_zero, overflow}, 32'(0));
        chk("rst_q", 32'(quotient), 32'(0));
        chk("rst_r", 32'(remainder), 32'(0));
        sb.delete();
        @(negedge clk);
        rst = 0;
        repeat (L + 4) @(negedge clk);
        chk("rst_no_done_q", 32'(quotient), 32'(0));
        run_op(32'h0001E240, 16'h03E8, 16'h007B, 16'h01C8, 1'b0, 1'b0);
        drain();
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
